mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default `ELEMENT_WIDTH, BRAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default `BRAM_ADDR_WIDTH, BRAM address width.
REQ-003 SHALL have parameter RD_LATENCY, default 2, BRAM read latency in cycles (1..4).
REQ-004 SHALL have parameter MAX_HOLD, default 1024, grant hold limit in cycles (guard only).
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  4  per-requester ownership request (0 input, 1 generate, 2 display, 3 compute).
REQ-008 wr_en / rd_en  input  4 each  per-requester write/read strobes.
REQ-009 wr_addr / rd_addr  input  4*ADDR_WIDTH each  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 wr_data  input  4*ELEMENT_WIDTH  packed write data.
REQ-011 grant  output  4  one-hot ownership.
REQ-012 rd_valid  output  4  per-requester read-data strobe.
REQ-013 rd_data  output  ELEMENT_WIDTH  read data, broadcast.
REQ-014 mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr  output  1/ADDR/ELEMENT/1/ADDR  BRAM ports.
REQ-015 mem_rd_data  input  ELEMENT_WIDTH  BRAM read data.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, OWN, DRAIN; at most one grant bit high at any time.
REQ-018 IDLE: if req!=0, winner = first set bit scanning from (last_owner+1) mod 4 upward; grant registered, high the cycle after req is sampled; -> OWN; last_owner <= winner.
REQ-019 OWN: grant held while req[owner]=1; mem_* driven combinationally from owner's strobes/addr/data; non-owner strobes ignored (no BRAM effect, no error).
REQ-020 Outside OWN, mem_wr_en=0 and mem_rd_en=0.
REQ-021 Write and read in same cycle both forwarded (independent ports).
REQ-022 req[owner] low in OWN -> grant cleared next cycle -> DRAIN.
REQ-023 DRAIN lasts exactly RD_LATENCY cycles, then IDLE; arbitration resumes only in IDLE.
REQ-024 Read tag pipeline RD_LATENCY deep: rd_valid[owner] pulses exactly RD_LATENCY cycles after the issuing mem_rd_en cycle, including during DRAIN; rd_data = mem_rd_data.
REQ-025 Back-to-back reads: one rd_valid pulse per issued read, order preserved.
REQ-026 Simultaneous owner release and new req: new req waits for DRAIN then IDLE arbitration.
REQ-027 Fairness: pointer rotation guarantees any held req granted within 3 ownership periods.
REQ-028 Owner strobes issued in the grant-clearing cycle are not forwarded.

Reset
REQ-029 rst_n low: state IDLE, grant=0, rd_valid=0, rd_data=0, mem_*=0, busy=0, last_owner=3, tag pipeline cleared, hold counter 0.
REQ-030 Reset mid-OWN or mid-DRAIN discards pending reads; no rd_valid after release.

Configuration
REQ-031 Macro ARB_STARVE_GUARD_EN defined: hold counter counts OWN cycles; at MAX_HOLD with any other req bit high, grant revoked (-> DRAIN) and sticky output-free event, counter resets on each grant.
REQ-032 Macro undefined: no counter, ownership unlimited; behaviour otherwise identical.

Verification
REQ-033 Reset, req=4'b0110 -> grant=4'b0010 one cycle later; after release + 2 DRAIN cycles, grant=4'b0100.
REQ-034 Owner 1 writes addr 5 data 7, then reads addr 5 -> mem_wr_en for one cycle, rd_valid[1] exactly 2 cycles after read with rd_data=7.
REQ-035 Owner 0 granted, requester 2 drives wr_en=1 addr 9 -> mem_wr_en stays 0, addr 9 unchanged.
REQ-036 Read issued last OWN cycle, req dropped -> rd_valid[owner] pulses during DRAIN; no other rd_valid bit.
REQ-037 rst_n asserted 1 cycle after rd issue -> grant=0, no rd_valid afterwards, busy=0.
REQ-038 ARB_STARVE_GUARD_EN, MAX_HOLD=16, req=4'b1001 held -> owner 0 revoked after 16 OWN cycles, grant=4'b1000 after DRAIN; without macro owner 0 retains grant indefinitely.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares a single dual-port BRAM (one write port, one read port)
//            between four requesters (0 input, 1 generate, 2 display,
//            3 compute).  Ownership is granted round-robin.  While a
//            requester owns the memory, its strobes, addresses and data are
//            forwarded to the BRAM.  After release, a drain period lets
//            in-flight reads return before the next arbitration.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req          in   4        per-requester ownership request
//   wr_en/rd_en  in   4 each   per-requester write/read strobes
//   wr_addr      in   4*AW     packed, requester i at [i*AW +: AW]
//   rd_addr      in   4*AW     packed, requester i at [i*AW +: AW]
//   wr_data      in   4*EW     packed, requester i at [i*EW +: EW]
//   grant        out  4        one-hot ownership (registered)
//   rd_valid     out  4        per-requester read-data strobe
//   rd_data      out  EW       read data, broadcast to all requesters
//   mem_*        out  -        BRAM write/read port controls
//   mem_rd_data  in   EW       BRAM read data
//   busy         out  1        high whenever the arbiter is not idle
// ----------------------------------------------------------------------------
// Configuration macro
//   ARB_STARVE_GUARD_EN : when defined, ownership is revoked after MAX_HOLD
//                         OWN cycles if any other requester is waiting.
// ============================================================================

`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 16
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif

module mem_port_arbiter #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH,
    parameter int RD_LATENCY    = 2,
    parameter int MAX_HOLD      = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 req,
    input  logic [3:0]                 wr_en,
    input  logic [3:0]                 rd_en,
    input  logic [4*ADDR_WIDTH-1:0]    wr_addr,
    input  logic [4*ADDR_WIDTH-1:0]    rd_addr,
    input  logic [4*ELEMENT_WIDTH-1:0] wr_data,
    output logic [3:0]                 grant,
    output logic [3:0]                 rd_valid,
    output logic [ELEMENT_WIDTH-1:0]   rd_data,
    output logic                       mem_wr_en,
    output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0]   mem_wr_data,
    output logic                       mem_rd_en,
    output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0]   mem_rd_data,
    output logic                       busy
);

    // Elaboration-time parameter sanity check.
    if (RD_LATENCY < 1 || RD_LATENCY > 4 || MAX_HOLD < 1) begin : g_param_check
        $error("mem_port_arbiter: RD_LATENCY must be 1..4 and MAX_HOLD >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] c_drain_last = 2'(RD_LATENCY - 1);

    // ------------------------------------------------------------------------
    // Unpack the per-requester buses so the owner can be selected by index.
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]    w_wr_addr_a [4];
    logic [ADDR_WIDTH-1:0]    w_rd_addr_a [4];
    logic [ELEMENT_WIDTH-1:0] w_wr_data_a [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign w_wr_addr_a[g] = wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_rd_addr_a[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wr_data_a[g] = wr_data[g*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] last_owner_q, last_owner_d;   // also the current owner in OWN
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       busy_q, busy_d;
    logic [3:0] tag_q [RD_LATENCY];
    logic [3:0] tag_d [RD_LATENCY];

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_hold_w = $clog2(MAX_HOLD + 1);
    logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
    logic                starve_event_q, starve_event_d;   // sticky, internal only
`endif

    logic [1:0] w_win_idx;
    logic [1:0] w_cand;
    logic [3:0] w_win_onehot;
    logic       w_revoke;
    logic       w_release;
    logic       w_fwd;

    // Round-robin winner: first set request bit scanning upward from the
    // position after the last owner.  Scanning offsets from high to low lets
    // the smallest offset overwrite the others, so no found-flag is needed.
    always_comb begin
        w_win_idx = 2'd0;
        w_cand    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_cand = last_owner_q + 2'(i + 1);
            if (req[w_cand]) begin
                w_win_idx = w_cand;
            end
        end
    end

    assign w_win_onehot = 4'b0001 << w_win_idx;

`ifdef ARB_STARVE_GUARD_EN
    // Revoke only once the hold limit is reached and someone else is waiting.
    assign w_revoke = (state_q == S_OWN) &&
                      (hold_cnt_q == c_hold_w'(MAX_HOLD)) &&
                      (|(req & ~grant_q));
`else
    assign w_revoke = 1'b0;
`endif

    // The cycle in which ownership ends (owner drops req or is revoked) is
    // the grant-clearing cycle; strobes in that cycle are not forwarded.
    assign w_release = !req[last_owner_q] || w_revoke;
    assign w_fwd     = (state_q == S_OWN) && !w_release;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        drain_cnt_d  = drain_cnt_q;
`ifdef ARB_STARVE_GUARD_EN
        hold_cnt_d     = hold_cnt_q;
        starve_event_d = starve_event_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d      = S_OWN;
                    grant_d      = w_win_onehot;
                    last_owner_d = w_win_idx;
`ifdef ARB_STARVE_GUARD_EN
                    hold_cnt_d   = '0;
`endif
                end
            end
            S_OWN: begin
                if (w_release) begin
                    state_d     = S_DRAIN;
                    grant_d     = 4'b0000;
                    drain_cnt_d = c_drain_last;
`ifdef ARB_STARVE_GUARD_EN
                    starve_event_d = starve_event_q | w_revoke;
`endif
                end
`ifdef ARB_STARVE_GUARD_EN
                else if (hold_cnt_q != c_hold_w'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;   // saturates at the limit
                end
`endif
            end
            S_DRAIN: begin
                // Exactly RD_LATENCY cycles, so every read issued while
                // owning has returned before the next arbitration.
                if (drain_cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Read tag pipeline: the owner's one-hot tag travels alongside the BRAM
    // read and emerges as rd_valid exactly RD_LATENCY cycles after issue.
    always_comb begin
        tag_d[0] = (w_fwd && rd_en[last_owner_q]) ? grant_q : 4'b0000;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 4'b0000;
            last_owner_q <= 2'd3;
            drain_cnt_q  <= 2'd0;
            busy_q       <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= 4'b0000;
            end
`ifdef ARB_STARVE_GUARD_EN
            hold_cnt_q     <= '0;
            starve_event_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            drain_cnt_q  <= drain_cnt_d;
            busy_q       <= busy_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
`ifdef ARB_STARVE_GUARD_EN
            hold_cnt_q     <= hold_cnt_d;
            starve_event_q <= starve_event_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign rd_valid = tag_q[RD_LATENCY-1];
    // Data is zero when no strobe is active so rd_data reads 0 in reset.
    assign rd_data  = (|rd_valid) ? mem_rd_data : '0;

    // BRAM ports follow the owner combinationally; idle values are zero.
    assign mem_wr_en   = w_fwd & wr_en[last_owner_q];
    assign mem_rd_en   = w_fwd & rd_en[last_owner_q];
    assign mem_wr_addr = w_fwd ? w_wr_addr_a[last_owner_q] : '0;
    assign mem_wr_data = w_fwd ? w_wr_data_a[last_owner_q] : '0;
    assign mem_rd_addr = w_fwd ? w_rd_addr_a[last_owner_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a behavioural
//            BRAM (read latency RDL) and a read-return scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int EW  = 16;
    localparam int AW  = 8;
    localparam int RDL = 2;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req;
    logic [3:0]        wr_en;
    logic [3:0]        rd_en;
    logic [4*AW-1:0]   wr_addr;
    logic [4*AW-1:0]   rd_addr;
    logic [4*EW-1:0]   wr_data;
    logic [3:0]        grant;
    logic [3:0]        rd_valid;
    logic [EW-1:0]     rd_data;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_wr_addr;
    logic [EW-1:0]     mem_wr_data;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [EW-1:0]     mem_rd_data;
    logic              busy;

    mem_port_arbiter #(
        .ELEMENT_WIDTH (EW),
        .ADDR_WIDTH    (AW),
        .RD_LATENCY    (RDL),
        .MAX_HOLD      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .wr_data     (wr_data),
        .grant       (grant),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Behavioural BRAM: registered read, total latency RDL (=2) cycles.
    // ------------------------------------------------------------------------
    function automatic logic [EW-1:0] init_val(input int a);
        return 16'hA5A5 ^ 16'(a);
    endfunction

    logic [EW-1:0] bram [256];
    logic [EW-1:0] rd_pipe1;

    initial begin
        for (int a = 0; a < 256; a++) bram[a] = init_val(a);
        rd_pipe1    = '0;
        mem_rd_data = '0;
    end

    always @(posedge clk) begin
        if (mem_wr_en) bram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) rd_pipe1 <= bram[mem_rd_addr];
        mem_rd_data <= rd_pipe1;
    end

    // ------------------------------------------------------------------------
    // Checking helpers and scoreboard
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [3:0]    port;
        logic [EW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];

    task automatic push(input logic [3:0] port, input logic [EW-1:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        e.due  = cyc + RDL;
        sb.push_back(e);
    endtask

    // Every cycle: either the scheduled return is present, or no strobe.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("rd_valid_port", 64'(rd_valid), 64'(e.port));
            check("rd_data", 64'(rd_data), 64'(e.data));
        end else begin
            check("rd_valid_idle", 64'(rd_valid), 64'd0);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        wr_en   = 4'b0000;
        rd_en   = 4'b0000;
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        wr_en[i]             = 1'b1;
        wr_addr[i*AW +: AW]  = AW'(a);
        wr_data[i*EW +: EW]  = EW'(d);
    endtask

    task automatic set_rd(input int i, input int a);
        rd_en[i]            = 1'b1;
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        bit got;
        got   = 1'b0;
        rst_n = 1'b0;
        req   = 4'b0000;
        clear_strobes();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_mem_wr_addr", 64'(mem_wr_addr), 64'd0);
        check("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
        check("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Requesters 1 and 2; pointer after reset starts at 0 -> 1 wins
        req = 4'b0110;
        tick();
        check("arb_first_grant", 64'(grant), 64'b0010);
        check("own_busy", 64'(busy), 64'd1);

        // Owner 1 writes 7 to address 5
        set_wr(1, 5, 7);
        #1;
        check("wr_fwd_en", 64'(mem_wr_en), 64'd1);
        check("wr_fwd_addr", 64'(mem_wr_addr), 64'd5);
        check("wr_fwd_data", 64'(mem_wr_data), 64'd7);
        check("wr_no_rd", 64'(mem_rd_en), 64'd0);

        // Back-to-back reads: 5, 20, 5
        tick();
        clear_strobes();
        set_rd(1, 5);
        #1;
        check("rd_fwd_en", 64'(mem_rd_en), 64'd1);
        check("rd_fwd_addr", 64'(mem_rd_addr), 64'd5);
        check("wr_single_cycle", 64'(mem_wr_en), 64'd0);
        push(4'b0010, 16'd7);
        tick();
        set_rd(1, 20);
        push(4'b0010, init_val(20));
        tick();
        set_rd(1, 5);
        push(4'b0010, 16'd7);

        // Release by requester 1 while 2 keeps requesting; a read strobe in
        // the grant-clearing cycle must not reach the BRAM
        tick();
        clear_strobes();
        req = 4'b0100;
        set_rd(1, 5);
        #1;
        check("release_rd_blocked", 64'(mem_rd_en), 64'd0);
        check("release_grant_held", 64'(grant), 64'b0010);
        tick();
        clear_strobes();
        check("drain1_grant", 64'(grant), 64'd0);
        check("drain1_busy", 64'(busy), 64'd1);
        tick();
        check("drain2_grant", 64'(grant), 64'd0);
        check("drain2_busy", 64'(busy), 64'd1);
        tick();
        check("idle_grant", 64'(grant), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        tick();
        check("arb_second_grant", 64'(grant), 64'b0100);

        // Owner 2 reads in its last OWN cycle; the return lands in DRAIN
        set_rd(2, 20);
        #1;
        check("last_rd_fwd", 64'(mem_rd_en), 64'd1);
        push(4'b0100, init_val(20));
        tick();
        clear_strobes();
        req = 4'b0000;
        tick();
        check("drain_rd_valid", 64'(rd_valid), 64'b0100);
        check("drain_grant", 64'(grant), 64'd0);
        tick();
        tick();

        // Owner 0; requester 2 tries to write address 9
        req = 4'b0001;
        tick();
        check("arb_owner0", 64'(grant), 64'b0001);
        set_wr(2, 9, 16'hBEEF);
        #1;
        check("nonowner_wr_blocked", 64'(mem_wr_en), 64'd0);
        check("nonowner_addr_zero", 64'(mem_wr_addr), 64'd0);

        // Simultaneous write and read by the owner, then read back
        tick();
        clear_strobes();
        set_rd(0, 9);
        set_wr(0, 30, 16'h1234);
        #1;
        check("dual_rd_en", 64'(mem_rd_en), 64'd1);
        check("dual_wr_en", 64'(mem_wr_en), 64'd1);
        check("dual_wr_addr", 64'(mem_wr_addr), 64'd30);
        push(4'b0001, init_val(9));
        tick();
        clear_strobes();
        set_rd(0, 30);
        push(4'b0001, 16'h1234);
        tick();
        clear_strobes();

        // Requester 3 waits while owner 0 holds on
        req = 4'b1001;
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 64 && !got; k++) begin
            tick();
            if (grant === 4'b1000) got = 1'b1;
        end
        check("guard_handover", 64'(grant), 64'b1000);
`else
        for (int k = 0; k < 40; k++) begin
            tick();
            check("hold_unlimited", 64'(grant), 64'b0001);
        end
`endif
        req = 4'b0000;
        repeat (4) tick();
        check("quiet_busy", 64'(busy), 64'd0);
        check("quiet_grant", 64'(grant), 64'd0);

        // Reset one cycle after a read is issued
        req = 4'b1000;
        tick();
        check("arb_owner3", 64'(grant), 64'b1000);
        set_rd(3, 5);
        #1;
        check("pre_rst_rd_fwd", 64'(mem_rd_en), 64'd1);
        tick();
        clear_strobes();
        rst_n = 1'b0;
        #1;
        check("midrst_grant", 64'(grant), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        check("midrst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        req   = 4'b0000;
        repeat (4) tick();
        check("post_rst_busy", 64'(busy), 64'd0);

        // Rotation: all request after reset -> 0, then 1 after 0 releases
        req = 4'b1111;
        tick();
        check("rr_grant0", 64'(grant), 64'b0001);
        req = 4'b1110;
        repeat (4) tick();
        check("rr_grant1", 64'(grant), 64'b0010);
        req = 4'b0000;
        repeat (5) tick();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
